dtw_query_framer: RTL and testbench



---
 rtl/dtw_query_framer.sv | 217 +++++++++++++++++++++
 tb/tb_dtw_query_framer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_query_framer.sv
// +-----------------------------------------------------------------------------+
// | Module      : dtw_query_framer                                              |
// | Description : Frames raw per-read ADC samples into fixed-length, offset-    |
// |               corrected query frames (tuser first, tlast last) for dtw_accel|
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module dtw_query_framer #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int QUERY_LEN       = 250,
  parameter int SKIP_SAMPLES    = 0,
  parameter int OFFSET          = 0,
  parameter int PAD_VALUE       = 0
) (
  input  logic                       i_axis_clk,
  input  logic                       i_axis_rst,
  input  logic                       i_axis_in_tvalid,
  output logic                       o_axis_in_tready,
  input  logic                       i_axis_in_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_in_tdata,
  output logic                       o_axis_out_tuser,
  output logic                       o_axis_out_tvalid,
  input  logic                       i_axis_out_tready,
  output logic                       o_axis_out_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
  output logic [31:0]                o_frame_cnt,
  output logic [31:0]                o_pad_cnt,
  output logic [31:0]                o_drop_cnt,
  output logic                       o_busy
);

  localparam int                 c_idx_w    = $clog2(QUERY_LEN);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(QUERY_LEN - 1);
  localparam logic [31:0]        c_skip_last = 32'(SKIP_SAMPLES - 1);

  typedef enum logic [1:0] {
    c_skip  = 2'd0,
    c_pass  = 2'd1,
    c_pad   = 2'd2,
    c_drain = 2'd3
  } state_t;

  // With no skip region every read starts straight in PASS.
  localparam state_t c_start = (SKIP_SAMPLES == 0) ? c_pass : c_skip;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [c_idx_w-1:0]         r_idx;
  logic [c_idx_w-1:0]         w_idx_nxt;
  logic [31:0]                r_skip_cnt;
  logic [31:0]                w_skip_nxt;
  logic                       r_out_tvalid;
  logic                       r_out_tuser;
  logic                       r_out_tlast;
  logic [AXIS_DATA_WIDTH-1:0] r_out_tdata;
  logic [31:0]                r_frame_cnt;
  logic [31:0]                r_pad_cnt;
  logic [31:0]                r_drop_cnt;

  logic                       w_slot_free;
  logic                       w_in_tready;
  logic                       w_in_acc;
  logic [SAMPLE_WIDTH-1:0]    w_sample;
  logic [SAMPLE_WIDTH-1:0]    w_res;
  logic [AXIS_DATA_WIDTH-1:0] w_xform;
  logic                       w_load;
  logic [AXIS_DATA_WIDTH-1:0] w_ld_data;
  logic                       w_ld_user;
  logic                       w_ld_last;
  logic                       w_pad_inc;
  logic                       w_drop_inc;
  logic                       w_unused;

  assign w_unused    = ^i_axis_in_tdata;
  assign w_slot_free = !r_out_tvalid || i_axis_out_tready;

  always_comb begin
    w_in_tready = 1'b1;
    case (r_state)
      c_pass:  w_in_tready = w_slot_free;
      c_pad:   w_in_tready = 1'b0;
      default: w_in_tready = 1'b1;
    endcase
  end

  assign w_in_acc = i_axis_in_tvalid && w_in_tready;

  // Saturating subtraction: samples at or below the offset clamp to zero.
  assign w_sample = i_axis_in_tdata[SAMPLE_WIDTH-1:0];
  always_comb begin
    w_res = '0;
    if (64'(w_sample) > 64'(OFFSET)) begin
      w_res = w_sample - SAMPLE_WIDTH'(OFFSET);
    end
  end
  assign w_xform = AXIS_DATA_WIDTH'(w_res);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_skip_nxt  = r_skip_cnt;
    w_load      = 1'b0;
    w_ld_data   = w_xform;
    w_ld_user   = 1'b0;
    w_ld_last   = 1'b0;
    w_pad_inc   = 1'b0;
    w_drop_inc  = 1'b0;
    case (r_state)
      c_skip: begin
        if (w_in_acc) begin
          if (i_axis_in_tlast) begin
            w_drop_inc = 1'b1;
            w_skip_nxt = '0;
          end else if (r_skip_cnt == c_skip_last) begin
            w_state_nxt = c_pass;
            w_idx_nxt   = '0;
            w_skip_nxt  = '0;
          end else begin
            w_skip_nxt = r_skip_cnt + 32'd1;
          end
        end
      end
      c_pass: begin
        if (w_in_acc) begin
          w_load    = 1'b1;
          w_ld_user = (r_idx == '0);
          w_ld_last = (r_idx == c_idx_last);
          if (r_idx == c_idx_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = i_axis_in_tlast ? c_start : c_drain;
          end else begin
            w_idx_nxt = r_idx + c_idx_w'(1);
            if (i_axis_in_tlast) begin
              w_state_nxt = c_pad;
              w_pad_inc   = 1'b1;
            end
          end
        end
      end
      c_pad: begin
        if (w_slot_free) begin
          w_load    = 1'b1;
          w_ld_data = AXIS_DATA_WIDTH'(PAD_VALUE);
          w_ld_last = (r_idx == c_idx_last);
          if (r_idx == c_idx_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = c_start;
          end else begin
            w_idx_nxt = r_idx + c_idx_w'(1);
          end
        end
      end
      c_drain: begin
        if (w_in_acc && i_axis_in_tlast) begin
          w_state_nxt = c_start;
        end
      end
      default: w_state_nxt = c_start;
    endcase
  end

  always_ff @(posedge i_axis_clk) begin
    if (i_axis_rst) begin
      r_state    <= c_start;
      r_idx      <= '0;
      r_skip_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_skip_cnt <= w_skip_nxt;
    end
  end

  always_ff @(posedge i_axis_clk) begin
    if (i_axis_rst) begin
      r_out_tvalid <= 1'b0;
      r_out_tuser  <= 1'b0;
      r_out_tlast  <= 1'b0;
      r_out_tdata  <= '0;
    end else if (w_load) begin
      r_out_tvalid <= 1'b1;
      r_out_tuser  <= w_ld_user;
      r_out_tlast  <= w_ld_last;
      r_out_tdata  <= w_ld_data;
    end else if (i_axis_out_tready) begin
      r_out_tvalid <= 1'b0;
    end
  end

  // Frames count on the downstream handshake of the tlast beat, not on load.
  always_ff @(posedge i_axis_clk) begin
    if (i_axis_rst) begin
      r_frame_cnt <= '0;
      r_pad_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_out_tvalid && i_axis_out_tready && r_out_tlast) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_pad_inc)  r_pad_cnt  <= r_pad_cnt + 32'd1;
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign o_axis_in_tready  = w_in_tready;
  assign o_axis_out_tvalid = r_out_tvalid;
  assign o_axis_out_tuser  = r_out_tuser;
  assign o_axis_out_tlast  = r_out_tlast;
  assign o_axis_out_tdata  = r_out_tdata;
  assign o_frame_cnt       = r_frame_cnt;
  assign o_pad_cnt         = r_pad_cnt;
  assign o_drop_cnt        = r_drop_cnt;
  assign o_busy            = (r_state != c_skip) || (r_skip_cnt != '0) || r_out_tvalid;

endmodule

`default_nettype wire

// File: tb/tb_dtw_query_framer.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_dtw_query_framer                                           |
// | Description : Directed scoreboard bench for dtw_query_framer                |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_dtw_query_framer;

  localparam int DW   = 32;
  localparam int QL   = 4;
  localparam int SKIP = 2;
  localparam int OFF  = 100;
  localparam int PADV = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic          in_tlast = 1'b0;
  logic [DW-1:0] in_tdata = '0;
  logic          out_tuser;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  logic          out_tlast;
  logic [DW-1:0] out_tdata;
  logic [31:0]   frame_cnt;
  logic [31:0]   pad_cnt;
  logic [31:0]   drop_cnt;
  logic          busy;

  dtw_query_framer #(
    .AXIS_DATA_WIDTH(DW), .SAMPLE_WIDTH(16), .QUERY_LEN(QL),
    .SKIP_SAMPLES(SKIP), .OFFSET(OFF), .PAD_VALUE(PADV)
  ) u_dut (
    .i_axis_clk(clk), .i_axis_rst(rst),
    .i_axis_in_tvalid(in_tvalid), .o_axis_in_tready(in_tready),
    .i_axis_in_tlast(in_tlast), .i_axis_in_tdata(in_tdata),
    .o_axis_out_tuser(out_tuser), .o_axis_out_tvalid(out_tvalid),
    .i_axis_out_tready(out_tready), .o_axis_out_tlast(out_tlast),
    .o_axis_out_tdata(out_tdata),
    .o_frame_cnt(frame_cnt), .o_pad_cnt(pad_cnt), .o_drop_cnt(drop_cnt),
    .o_busy(busy)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          in_low = 0;
  bit          toggle_en = 1'b0;
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: held high, or alternating every cycle when toggling.
  initial forever begin
    @(posedge clk);
    #1;
    if (toggle_en) out_tready = ~out_tready;
    else           out_tready = 1'b1;
  end

  // Output monitor: pops the scoreboard on every handshake, checks hold stability.
  initial begin
    logic        held;
    logic [33:0] hold_v;
    logic [33:0] e;
    held = 1'b0;
    hold_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (!in_tready) in_low++;
        if (held && out_tvalid) check("hold_stable", {out_tdata, out_tuser, out_tlast}, hold_v);
        held = 1'b0;
        if (out_tvalid && out_tready) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat", {out_tdata, out_tuser, out_tlast}, e);
          end
        end else if (out_tvalid) begin
          held = 1'b1;
          hold_v = {out_tdata, out_tuser, out_tlast};
        end
      end
    end
  end

  // Reference model of one complete read: skip, transform, truncate or pad.
  function automatic void model_push(input int unsigned smp[$]);
    int unsigned v;
    if (smp.size() <= SKIP) return;
    for (int i = 0; i < QL; i++) begin
      if (SKIP + i < smp.size()) v = (smp[SKIP+i] > OFF) ? smp[SKIP+i] - OFF : 0;
      else v = PADV;
      exp_q.push_back({v[DW-1:0], (i == 0) ? 1'b1 : 1'b0, (i == QL - 1) ? 1'b1 : 1'b0});
    end
  endfunction

  task automatic send_read(input int unsigned smp[$], input bit has_last);
    if (has_last) model_push(smp);
    for (int i = 0; i < smp.size(); i++) begin
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      in_tvalid = 1'b1;
      in_tdata  = smp[i];
      in_tlast  = has_last && (i == smp.size() - 1);
      while (!ok && n < 200) begin
        @(negedge clk);
        ok = in_tready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!ok) check("in_accept", ok, 1);
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_tvalid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input int f, input int p, input int d);
    check("frame_cnt", frame_cnt, f);
    check("pad_cnt", pad_cnt, p);
    check("drop_cnt", drop_cnt, d);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", out_tvalid, 0);
    check("rst_tdata", out_tdata, 0);
    check("rst_tuser_tlast", {out_tuser, out_tlast}, 0);
    check("rst_busy", busy, 0);
    check_cnt(0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_tready", in_tready, 1);

    // Long read: truncated to the query, tail drained.
    send_read('{10, 20, 150, 200, 300, 400, 500, 600}, 1'b1);
    wait_idle();
    check_cnt(1, 0, 0);

    // Short read: padded, input stalled during the two pad beats.
    in_low = 0;
    send_read('{10, 20, 150, 90}, 1'b1);
    wait_idle();
    check("pad_in_tready_low", in_low, 2);
    check_cnt(2, 1, 0);

    // Read ending inside the skip region is dropped; next read is framed normally.
    send_read('{5, 6}, 1'b1);
    wait_idle();
    check_cnt(2, 1, 1);
    send_read('{7, 8, 150, 200, 250, 300}, 1'b1);
    wait_idle();
    check_cnt(3, 1, 1);

    // Exact-length read returns straight to skip.
    send_read('{1, 2, 110, 120, 130, 140}, 1'b1);
    wait_idle();
    check("exact_busy", busy, 0);
    check_cnt(4, 1, 1);

    // Downstream backpressure alternating every cycle.
    toggle_en = 1'b1;
    send_read('{0, 0, 200, 300, 400, 500, 600, 700, 800, 900}, 1'b1);
    wait_idle();
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cnt(5, 1, 1);

    // Reset mid-frame after two output beats.
    exp_q.push_back({32'd50, 1'b1, 1'b0});
    exp_q.push_back({32'd100, 1'b0, 1'b0});
    send_read('{10, 20, 150, 200}, 1'b0);
    wait_idle();
    check("midframe_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_tvalid", out_tvalid, 0);
    check("mrst_tdata", out_tdata, 0);
    check("mrst_tuser_tlast", {out_tuser, out_tlast}, 0);
    check("mrst_busy", busy, 0);
    check_cnt(0, 0, 0);
    send_read('{11, 12, 150, 200, 250, 300, 350}, 1'b1);
    wait_idle();
    check_cnt(1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
